// File: rtl/shape_processor_modeling_pkg.sv
// Shared types for the shape processor control SFR and its bus initiator:
// field enums, SFR layout, response status and expected-value resolution.
package shape_processor_modeling;

  typedef enum logic [1:0] {
    CIRCLE     = 2'd0,
    RECTANGLE  = 2'd1,
    TRIANGLE   = 2'd2,
    KEEP_SHAPE = 2'd3
  } shape_e;

  typedef enum logic [1:0] {
    PERIMETER      = 2'd0,
    AREA           = 2'd1,
    IS_SQUARE      = 2'd2,
    KEEP_OPERATION = 2'd3
  } operation_e;

  typedef struct packed {
    logic [27:0] reserved;
    operation_e  operation;
    shape_e      shape;
  } ctrl_sfr_reg;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_REJECTED = 2'd1,
    RSP_MISMATCH = 2'd2
  } rsp_status_e;

  // A rejected write leaves the SFR untouched; otherwise KEEP fields hold their value.
  function automatic ctrl_sfr_reg resolve_expected(input ctrl_sfr_reg shadow,
                                                   input shape_e      shape,
                                                   input operation_e  operation,
                                                   input logic        err_seen);
    ctrl_sfr_reg result;
    result = shadow;
    if (!err_seen) begin
      if (shape != KEEP_SHAPE) result.shape = shape;
      if (operation != KEEP_OPERATION) result.operation = operation;
    end
    return result;
  endfunction

endpackage

// File: rtl/shape_processor_initiator_shadow.sv
// Shadow copy of the control SFR: captures read-backs, resolves the expected
// post-command value and derives the response status.
module shape_processor_initiator_shadow
  import shape_processor_modeling::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        commit_en,
  input  logic [31:0] read_data,
  input  shape_e      cmd_shape,
  input  operation_e  cmd_operation,
  input  logic        err_seen,
  output shape_e      shadow_shape,
  output operation_e  shadow_operation,
  output logic        shadow_valid,
  output rsp_status_e status
);

  ctrl_sfr_reg shadow_reg;
  logic        shadow_valid_reg;
  ctrl_sfr_reg expected;

  assign expected = resolve_expected(shadow_reg, cmd_shape, cmd_operation, err_seen);

  always_comb begin
    status = RSP_OK;
`ifdef SHAPE_PROCESSOR_INITIATOR_READBACK_EN
    // A wrong read-back outranks a rejection.
    if (read_data != expected) status = RSP_MISMATCH;
    else if (err_seen) status = RSP_REJECTED;
`else
    if (err_seen) status = RSP_REJECTED;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg       <= '0;
      shadow_valid_reg <= 1'b0;
    end else if (capture_en) begin
      shadow_reg       <= ctrl_sfr_reg'(read_data);
      shadow_valid_reg <= 1'b1;
    end else if (commit_en) begin
      shadow_reg <= expected;
    end
  end

  assign shadow_shape     = shadow_reg.shape;
  assign shadow_operation = shadow_reg.operation;
  assign shadow_valid     = shadow_valid_reg;

endmodule

// File: rtl/shape_processor_initiator.sv
// Bus initiator turning shape/operation commands into control SFR writes with
// error-window and read-back confirmation. Option: SHAPE_PROCESSOR_INITIATOR_READBACK_EN.
module shape_processor_initiator
  import shape_processor_modeling::*;
#(
  parameter int ERR_WINDOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  shape_e      cmd_shape,
  input  operation_e  cmd_operation,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output rsp_status_e rsp_status,
  output shape_e      rsp_shape,
  output operation_e  rsp_operation,
  output logic [15:0] err_count,
  output logic        write,
  output logic [31:0] write_data,
  output logic        read,
  input  logic [31:0] read_data,
  input  logic        error
);

  localparam int CNT_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;

  typedef enum logic [2:0] {
    SYNC_RD, SYNC_WAIT, IDLE, WR, WR_WAIT, RD, RD_WAIT, RESP
  } state_e;

  state_e      state_reg, state_next;
  shape_e      cmd_shape_reg;
  operation_e  cmd_operation_reg;
  logic        err_seen_reg;
  logic [CNT_W-1:0] win_cnt_reg;
  rsp_status_e status_reg;
  logic [15:0] err_count_reg;

  logic        win_last, err_any, capture_en, commit_en, status_load, shadow_valid;
  shape_e      shadow_shape;
  operation_e  shadow_operation;
  rsp_status_e status;

  assign win_last = (win_cnt_reg == CNT_W'(ERR_WINDOW - 1));
  // Include the current cycle's error so the final window cycle counts.
  assign err_any  = err_seen_reg | ((state_reg == WR_WAIT) & error);

  shape_processor_initiator_shadow u_shadow (
    .clk              (clk),
    .rst              (rst),
    .capture_en       (capture_en),
    .commit_en        (commit_en),
    .read_data        (read_data),
    .cmd_shape        (cmd_shape_reg),
    .cmd_operation    (cmd_operation_reg),
    .err_seen         (err_any),
    .shadow_shape     (shadow_shape),
    .shadow_operation (shadow_operation),
    .shadow_valid     (shadow_valid),
    .status           (status)
  );

  always_comb begin
    state_next  = state_reg;
    cmd_ready   = 1'b0;
    write       = 1'b0;
    read        = 1'b0;
    rsp_valid   = 1'b0;
    capture_en  = 1'b0;
    commit_en   = 1'b0;
    status_load = 1'b0;
    case (state_reg)
      SYNC_RD: begin
        read       = 1'b1;
        state_next = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        capture_en = 1'b1;
        state_next = IDLE;
      end
      IDLE: begin
        cmd_ready = shadow_valid;
        if (cmd_valid && shadow_valid) state_next = WR;
      end
      WR: begin
        write      = 1'b1;
        state_next = WR_WAIT;
      end
      WR_WAIT: begin
        if (win_last) begin
`ifdef SHAPE_PROCESSOR_INITIATOR_READBACK_EN
          state_next = RD;
`else
          commit_en   = 1'b1;
          status_load = 1'b1;
          state_next  = RESP;
`endif
        end
      end
`ifdef SHAPE_PROCESSOR_INITIATOR_READBACK_EN
      RD: begin
        read       = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        capture_en  = 1'b1;
        status_load = 1'b1;
        state_next  = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = SYNC_RD;
    endcase
    // Strobes must drop in the very cycle reset is raised.
    if (rst) begin
      cmd_ready   = 1'b0;
      write       = 1'b0;
      read        = 1'b0;
      rsp_valid   = 1'b0;
      capture_en  = 1'b0;
      commit_en   = 1'b0;
      status_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= SYNC_RD;
      cmd_shape_reg     <= CIRCLE;
      cmd_operation_reg <= PERIMETER;
      err_seen_reg      <= 1'b0;
      win_cnt_reg       <= '0;
      status_reg        <= RSP_OK;
      err_count_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (cmd_valid && cmd_ready) begin
        cmd_shape_reg     <= cmd_shape;
        cmd_operation_reg <= cmd_operation;
        err_seen_reg      <= 1'b0;
      end
      if (state_reg == WR) win_cnt_reg <= '0;
      else if (state_reg == WR_WAIT && !win_last) win_cnt_reg <= win_cnt_reg + CNT_W'(1);
      if (state_reg == WR_WAIT) err_seen_reg <= err_any;
      if (status_load) status_reg <= status;
      if (rsp_valid && rsp_ready && status_reg == RSP_REJECTED && err_count_reg != 16'hFFFF)
        err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign write_data    = write ? {28'd0, cmd_operation_reg, cmd_shape_reg} : 32'd0;
  assign rsp_status    = rsp_valid ? status_reg : RSP_OK;
  assign rsp_shape     = rsp_valid ? shadow_shape : CIRCLE;
  assign rsp_operation = rsp_valid ? shadow_operation : PERIMETER;
  assign err_count     = err_count_reg;

endmodule

// File: tb/tb_shape_processor_initiator.sv
// Directed bench for shape_processor_initiator with a small SFR responder that can
// reject (error pulse) or silently ignore writes.
module tb_shape_processor_initiator;
  import shape_processor_modeling::*;

`ifdef SHAPE_PROCESSOR_INITIATOR_READBACK_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  shape_e      cmd_shape, rsp_shape;
  operation_e  cmd_operation, rsp_operation;
  rsp_status_e rsp_status;
  logic [15:0] err_count;
  logic        write, read;
  logic [31:0] write_data;
  logic [31:0] read_data = 32'd0;
  logic        error = 1'b0;
  logic [31:0] sfr = 32'd0;
  bit          reject_mode = 1'b0;
  bit          ignore_mode = 1'b0;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  shape_processor_initiator #(.ERR_WINDOW(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_shape     (cmd_shape),
    .cmd_operation (cmd_operation),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_status    (rsp_status),
    .rsp_shape     (rsp_shape),
    .rsp_operation (rsp_operation),
    .err_count     (err_count),
    .write         (write),
    .write_data    (write_data),
    .read          (read),
    .read_data     (read_data),
    .error         (error)
  );

  // Responder: KEEP fields retain their value, read data appears the cycle after read.
  always @(posedge clk) begin
    error <= write && reject_mode;
    if (write && !reject_mode && !ignore_mode) begin
      if (write_data[1:0] != 2'd3) sfr[1:0] <= write_data[1:0];
      if (write_data[3:2] != 2'd3) sfr[3:2] <= write_data[3:2];
    end
    if (read) read_data <= sfr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends at posedge+1 of a cycle where the DUT is in IDLE.
  task automatic run_cmd(input shape_e s, input operation_e o, input int hold,
                         input rsp_status_e exp_status, input shape_e exp_shape,
                         input operation_e exp_op, input logic [31:0] exp_wd);
    cmd_shape = s;
    cmd_operation = o;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("hs_cmd_ready", cmd_ready, 1'b1);
    next_cycle();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("wr_strobe", write, 1'b1);
    check("wr_data", write_data, exp_wd);
    check("wr_no_read", read, 1'b0);
    next_cycle();
    @(negedge clk);
    check("wr_single", write, 1'b0);
    for (int c = 3; c < LAT; c++) begin
      next_cycle();
      @(negedge clk);
      check("rsp_early", rsp_valid, 1'b0);
      if (c == 3) check("rd_strobe", read, 1'b1);
    end
    next_cycle();
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_status", rsp_status, exp_status);
    check("rsp_shape", rsp_shape, exp_shape);
    check("rsp_operation", rsp_operation, exp_op);
    check("rsp_cmd_ready", cmd_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      next_cycle();
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_status", rsp_status, exp_status);
      check("hold_shape", rsp_shape, exp_shape);
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    next_cycle();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_cmd_ready", cmd_ready, 1'b1);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_shape = CIRCLE;
    cmd_operation = PERIMETER;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_read", read, 1'b0);
    check("rst_write", write, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_err_count", err_count, 16'd0);

    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("sync_read_c1", read, 1'b1);
    check("sync_ready_c1", cmd_ready, 1'b0);
    next_cycle();
    @(negedge clk);
    check("sync_read_c2", read, 1'b0);
    check("sync_ready_c2", cmd_ready, 1'b0);
    next_cycle();
    @(negedge clk);
    check("sync_ready_c3", cmd_ready, 1'b1);
    check("sync_rsp_valid", rsp_valid, 1'b0);
    check("sync_rsp_status", rsp_status, RSP_OK);
    next_cycle();

    run_cmd(RECTANGLE, AREA, 0, RSP_OK, RECTANGLE, AREA, 32'h5);
    run_cmd(KEEP_SHAPE, IS_SQUARE, 0, RSP_OK, RECTANGLE, IS_SQUARE, 32'hB);
    check("err_count_before_reject", err_count, 16'd0);

    reject_mode = 1'b1;
    run_cmd(CIRCLE, IS_SQUARE, 0, RSP_REJECTED, RECTANGLE, IS_SQUARE, 32'h8);
    reject_mode = 1'b0;
    check("err_count_after_reject", err_count, 16'd1);

    ignore_mode = 1'b1;
`ifdef SHAPE_PROCESSOR_INITIATOR_READBACK_EN
    run_cmd(TRIANGLE, PERIMETER, 3, RSP_MISMATCH, RECTANGLE, IS_SQUARE, 32'h2);
`else
    run_cmd(TRIANGLE, PERIMETER, 3, RSP_OK, TRIANGLE, PERIMETER, 32'h2);
`endif
    ignore_mode = 1'b0;
    check("err_count_after_ignore", err_count, 16'd1);

    // Reset while the error window is open.
    cmd_shape = CIRCLE;
    cmd_operation = AREA;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("mid_hs_ready", cmd_ready, 1'b1);
    next_cycle();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_write", write, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_write", write, 1'b0);
    check("mid_rst_read", read, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rel_read_c1", read, 1'b1);
    check("rel_rsp_valid", rsp_valid, 1'b0);
    check("rel_err_count", err_count, 16'd0);
    next_cycle();
    @(negedge clk);
    check("rel_read_c2", read, 1'b0);
    next_cycle();
    @(negedge clk);
    check("rel_ready_c3", cmd_ready, 1'b1);
    check("rel_rsp_valid_c3", rsp_valid, 1'b0);
    next_cycle();

    // Shadow was reloaded by the sync read: SFR now holds CIRCLE/AREA.
    run_cmd(KEEP_SHAPE, KEEP_OPERATION, 0, RSP_OK, CIRCLE, AREA, 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/shape_processor_initiator.md
# shape_processor_initiator

Bus initiator for the shape processor's control SFR. It accepts shape/operation commands on a valid/ready interface and turns each one into a control-register write on the write/read bus. It then confirms the outcome through the error strobe and an SFR read-back, and returns a per-command status. It sits between the command source (firmware model or upstream sequencer) and `shape_processor`, on the other end of the bus that the processor responds to.

## Interface
- `ERR_WINDOW`, default 1: number of cycles after a `write` strobe during which `error` is sampled (≥1).
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted when high together with `cmd_valid`.
- `cmd_shape` input `shape_e`: requested shape; `KEEP_SHAPE` allowed.
- `cmd_operation` input `operation_e`: requested operation; `KEEP_OPERATION` allowed.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed.
- `rsp_status` output `rsp_status_e` (2 bits): OK=0, REJECTED=1, MISMATCH=2.
- `rsp_shape`, `rsp_operation` output: SFR content after the command (shadow).
- `err_count` output 16: saturating count of REJECTED responses.
- `write` output 1, `write_data` output 32: single-cycle write strobe and data. Non-field bits are 0.
- `read` output 1: single-cycle read strobe.
- `read_data` input 32: SFR content, valid in the cycle after `read`.
- `error` input 1: responder rejection pulse.

## Operation
- **Reset:** all outputs 0; `err_count` = 0; shadow invalid; FSM → SYNC_RD.
- **FSM states:** SYNC_RD, SYNC_WAIT, IDLE, WR, WR_WAIT, RD, RD_WAIT, RESP.
- **SYNC_RD:** assert `read` → SYNC_WAIT. SYNC_WAIT captures `read_data` into the shadow → IDLE.
- **IDLE:** `cmd_ready`=1. On handshake, latch the command → WR. `cmd_ready` is 0 in every other state.
- **WR:** `write`=1. `write_data` places the latched fields per `ctrl_sfr_reg` → WR_WAIT.
- **WR_WAIT:** lasts exactly `ERR_WINDOW` cycles and ORs `error` into `err_seen` → RD.
- **Expected SFR value:**
  - If `err_seen`: the shadow value.
  - Otherwise, per field: a KEEP value takes the shadow field; any other value takes the command field.
- **RD:** `read`=1 → RD_WAIT. RD_WAIT captures `read_data` into the shadow → RESP.
- **Status:**
  - OK if `!err_seen` and read-back == expected.
  - REJECTED if `err_seen` and read-back == expected.
  - MISMATCH otherwise; MISMATCH takes priority over REJECTED.
- **RESP:** `rsp_valid`=1; status and fields are held stable until `rsp_ready` → IDLE.
- **`err_count`:** increments on REJECTED at the handshake and saturates at 0xFFFF.
- `error` outside WR_WAIT is ignored.
- Reserved and illegal combinations are forwarded unfiltered. Checking is the responder's job; the initiator only reports the result.

## Timing
- With `ERR_WINDOW`=1 and the command handshake at cycle 0:
  - `write` at cycle 1.
  - error sampled at cycle 2.
  - `read` at cycle 3.
  - capture at cycle 4.
  - `rsp_valid` at cycle 5.
- General latency to `rsp_valid` is `4+ERR_WINDOW` cycles.
- `rsp_valid` and `rsp_ready` in the same cycle: the next command can be accepted one cycle later (IDLE).
- After reset release, `read` is asserted in the first cycle and `cmd_ready` rises on the third.
- Reset mid-operation: the command is discarded, no response is issued, strobes drop in the same cycle, and the FSM restarts at SYNC_RD.
- `write` and `read` are never high together and never high two consecutive cycles.

## Configuration
- **`SHAPE_PROCESSOR_INITIATOR_READBACK_EN` defined:** behaviour as above.
- **`SHAPE_PROCESSOR_INITIATOR_READBACK_EN` undefined:**
  - RD and RD_WAIT are removed; WR_WAIT → RESP.
  - Status is REJECTED if `err_seen`, else OK; MISMATCH never occurs.
  - The shadow is loaded with the expected value.
  - Latency is `2+ERR_WINDOW` cycles.
  - The SYNC read after reset is kept.

## Structure
- `rsp_status_e` and the expected-value resolution function are added to `shape_processor_modeling`.
- That package already provides `shape_e`, `operation_e`, the KEEP values and `ctrl_sfr_reg`.
- One sub-module, `shape_processor_initiator_shadow`: it holds the shadow, resolves the expected value and compares.

## Test plan
- Reset; SFR = CIRCLE/PERIMETER → `read` at cycle 1; `cmd_ready` at cycle 3; `rsp_*` stay 0.
- Command RECTANGLE/AREA accepted at cycle 0 → `write` at cycle 1 with those fields, `read` at cycle 3, `rsp_valid` at cycle 5, status OK, rsp RECTANGLE/AREA.
- Then KEEP_SHAPE/IS_SQUARE → OK, rsp RECTANGLE/IS_SQUARE.
- Then CIRCLE/IS_SQUARE with the responder pulsing `error` at cycle 2 → REJECTED, rsp RECTANGLE/IS_SQUARE, `err_count`=1.
- Faulty responder that ignores TRIANGLE/PERIMETER without `error` → MISMATCH, rsp shows the old SFR content. Without the macro, the same stimulus → OK at cycle 3.
- Hold `rsp_ready` low 3 cycles → response stable, `cmd_ready`=0. Assert `rst` during WR_WAIT → no response; `read` on the first cycle after release.
